// File: rtl/pc_sequencer.sv
// Next-PC selection and pipeline stall/flush control for the 5-stage core.
// Detects load-use and branch-operand hazards in ID and drains the pipeline on halt.
module pc_sequencer #(
    parameter logic [31:0] RESET_PC     = 32'h0000_0000,
    parameter int unsigned DRAIN_CYCLES = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] pc_current,
    input  logic        idex_mem_read,
    input  logic        idex_reg_write,
    input  logic [4:0]  idex_rt,
    input  logic [4:0]  idex_rd,
    input  logic [4:0]  ifid_rs,
    input  logic [4:0]  ifid_rt,
    input  logic        ifid_uses_rt,
    input  logic        id_is_branch,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic        jump,
    input  logic [31:0] jump_target,
    input  logic        halt,
    output logic [31:0] pc_next,
    output logic        pc_hold,
    output logic        ifid_hold,
    output logic        ifid_flush,
    output logic        idex_flush,
    output logic        halted,
    output logic [15:0] stall_count,
    output logic [15:0] flush_count
);

    localparam logic [1:0] ST_RUN    = 2'd0;
    localparam logic [1:0] ST_DRAIN  = 2'd1;
    localparam logic [1:0] ST_HALTED = 2'd2;

    localparam logic [3:0] DRAIN_LOAD = 4'(DRAIN_CYCLES);

    logic [1:0] state;
    logic [1:0] state_nxt;
    logic [3:0] drain_cnt;
    logic       lu;
    logic       bh;
    logic       hz;
    logic       stall_evt;
    logic       flush_evt;
    logic       halt_evt;

    assign lu = idex_mem_read && (idex_rt != 5'd0) &&
                ((idex_rt == ifid_rs) || (ifid_uses_rt && (idex_rt == ifid_rt)));
    assign bh = id_is_branch && idex_reg_write && (idex_rd != 5'd0) &&
                ((idex_rd == ifid_rs) || (idex_rd == ifid_rt));
    assign hz = lu || bh;

    // Hazards outrank every redirect so a stalled branch/jump/halt is replayed cleanly.
    always_comb begin
        pc_next    = pc_current + 32'd4;
        pc_hold    = 1'b0;
        ifid_hold  = 1'b0;
        ifid_flush = 1'b0;
        idex_flush = 1'b0;
        halted     = 1'b0;
        state_nxt  = state;
        stall_evt  = 1'b0;
        flush_evt  = 1'b0;
        halt_evt   = 1'b0;
        if (reset) begin
            pc_next    = RESET_PC;
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
        end else begin
            case (state)
                ST_RUN: begin
                    if (hz) begin
                        pc_hold    = 1'b1;
                        ifid_hold  = 1'b1;
                        idex_flush = 1'b1;
                        stall_evt  = 1'b1;
                    end else if (halt) begin
                        pc_hold    = 1'b1;
                        ifid_flush = 1'b1;
                        state_nxt  = ST_DRAIN;
                        halt_evt   = 1'b1;
                    end else if (jump) begin
                        pc_next    = jump_target;
                        ifid_flush = 1'b1;
                        flush_evt  = 1'b1;
                    end else if (branch_taken) begin
                        pc_next    = branch_target;
                        ifid_flush = 1'b1;
                        flush_evt  = 1'b1;
                    end
                end
                ST_DRAIN: begin
                    pc_next    = pc_current;
                    pc_hold    = 1'b1;
                    ifid_flush = 1'b1;
                    if (drain_cnt == 4'd1) begin
                        state_nxt = ST_HALTED;
                    end
                end
                ST_HALTED: begin
                    pc_next    = pc_current;
                    pc_hold    = 1'b1;
                    ifid_flush = 1'b1;
                    halted     = 1'b1;
                end
                default: begin
                    state_nxt = ST_RUN;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ST_RUN;
            drain_cnt   <= 4'd0;
            stall_count <= 16'd0;
            flush_count <= 16'd0;
        end else begin
            state <= state_nxt;
            if (halt_evt) begin
                drain_cnt <= DRAIN_LOAD;
            end else if ((state == ST_DRAIN) && (drain_cnt != 4'd0)) begin
                drain_cnt <= drain_cnt - 4'd1;
            end
            if (stall_evt && (stall_count != 16'hFFFF)) begin
                stall_count <= stall_count + 16'd1;
            end
            if (flush_evt && (flush_count != 16'hFFFF)) begin
                flush_count <= flush_count + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: a vector table for single-cycle decisions,
// plus hand-written sequences for reset, halt drain and reset during drain.
module tb_pc_sequencer;

    logic        clk;
    logic        reset;
    logic [31:0] pc_current;
    logic        idex_mem_read;
    logic        idex_reg_write;
    logic [4:0]  idex_rt;
    logic [4:0]  idex_rd;
    logic [4:0]  ifid_rs;
    logic [4:0]  ifid_rt;
    logic        ifid_uses_rt;
    logic        id_is_branch;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        jump;
    logic [31:0] jump_target;
    logic        halt;
    logic [31:0] pc_next;
    logic        pc_hold;
    logic        ifid_hold;
    logic        ifid_flush;
    logic        idex_flush;
    logic        halted;
    logic [15:0] stall_count;
    logic [15:0] flush_count;

    int checks;
    int errors;
    int exp_stall;
    int exp_flush;

    typedef struct {
        logic [31:0] pc;
        logic        mem_read;
        logic        reg_write;
        logic [4:0]  ex_rt;
        logic [4:0]  ex_rd;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic        uses_rt;
        logic        is_br;
        logic        taken;
        logic [31:0] btgt;
        logic        jmp;
        logic [31:0] jtgt;
        logic [31:0] e_pc_next;
        logic        e_pc_hold;
        logic        e_ifid_hold;
        logic        e_ifid_flush;
        logic        e_idex_flush;
        int          e_stall_inc;
        int          e_flush_inc;
    } vec_t;

    localparam int NVEC = 13;
    vec_t vecs [NVEC];

    pc_sequencer #(
        .RESET_PC    (32'h0000_0000),
        .DRAIN_CYCLES(4)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .pc_current    (pc_current),
        .idex_mem_read (idex_mem_read),
        .idex_reg_write(idex_reg_write),
        .idex_rt       (idex_rt),
        .idex_rd       (idex_rd),
        .ifid_rs       (ifid_rs),
        .ifid_rt       (ifid_rt),
        .ifid_uses_rt  (ifid_uses_rt),
        .id_is_branch  (id_is_branch),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .jump          (jump),
        .jump_target   (jump_target),
        .halt          (halt),
        .pc_next       (pc_next),
        .pc_hold       (pc_hold),
        .ifid_hold     (ifid_hold),
        .ifid_flush    (ifid_flush),
        .idex_flush    (idex_flush),
        .halted        (halted),
        .stall_count   (stall_count),
        .flush_count   (flush_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string what, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", what, act, exp);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        pc_current     = v.pc;
        idex_mem_read  = v.mem_read;
        idex_reg_write = v.reg_write;
        idex_rt        = v.ex_rt;
        idex_rd        = v.ex_rd;
        ifid_rs        = v.rs;
        ifid_rt        = v.rt;
        ifid_uses_rt   = v.uses_rt;
        id_is_branch   = v.is_br;
        branch_taken   = v.taken;
        branch_target  = v.btgt;
        jump           = v.jmp;
        jump_target    = v.jtgt;
        halt           = 1'b0;
    endtask

    task automatic clearInputs(input logic [31:0] pc);
        pc_current     = pc;
        idex_mem_read  = 1'b0;
        idex_reg_write = 1'b0;
        idex_rt        = 5'd0;
        idex_rd        = 5'd0;
        ifid_rs        = 5'd0;
        ifid_rt        = 5'd0;
        ifid_uses_rt   = 1'b0;
        id_is_branch   = 1'b0;
        branch_taken   = 1'b0;
        branch_target  = 32'd0;
        jump           = 1'b0;
        jump_target    = 32'd0;
        halt           = 1'b0;
    endtask

    task automatic checkCounters(input string tag);
        checkOutput({tag, " stall_count"}, {16'd0, stall_count}, 32'(exp_stall));
        checkOutput({tag, " flush_count"}, {16'd0, flush_count}, 32'(exp_flush));
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        exp_stall = 0;
        exp_flush = 0;

        //             pc            mr    rw    ert    erd    rs     rt     urt   br    tk    btgt          j     jtgt          pc_next       hold  ifh   iff   idf  si fi
        vecs[0]  = '{32'h100,      1'b0, 1'b0, 5'd0, 5'd0, 5'd1, 5'd2, 1'b1, 1'b0, 1'b0, 32'h0,   1'b0, 32'h0,   32'h104, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0};
        vecs[1]  = '{32'hFFFF_FFFC,1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 32'h0,   1'b0, 32'h0,   32'h0,   1'b0, 1'b0, 1'b0, 1'b0, 0, 0};
        vecs[2]  = '{32'h100,      1'b1, 1'b0, 5'd8, 5'd0, 5'd8, 5'd2, 1'b1, 1'b0, 1'b0, 32'h0,   1'b0, 32'h0,   32'h104, 1'b1, 1'b1, 1'b0, 1'b1, 1, 0};
        vecs[3]  = '{32'h100,      1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 32'h0,   1'b0, 32'h0,   32'h104, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0};
        vecs[4]  = '{32'h100,      1'b1, 1'b0, 5'd9, 5'd0, 5'd3, 5'd9, 1'b1, 1'b0, 1'b0, 32'h0,   1'b0, 32'h0,   32'h104, 1'b1, 1'b1, 1'b0, 1'b1, 1, 0};
        vecs[5]  = '{32'h100,      1'b1, 1'b0, 5'd9, 5'd0, 5'd3, 5'd9, 1'b0, 1'b0, 1'b0, 32'h0,   1'b0, 32'h0,   32'h104, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0};
        vecs[6]  = '{32'h100,      1'b1, 1'b0, 5'd8, 5'd0, 5'd8, 5'd2, 1'b1, 1'b1, 1'b1, 32'h200, 1'b0, 32'h0,   32'h104, 1'b1, 1'b1, 1'b0, 1'b1, 1, 0};
        vecs[7]  = '{32'h100,      1'b0, 1'b0, 5'd8, 5'd0, 5'd8, 5'd2, 1'b1, 1'b1, 1'b1, 32'h200, 1'b0, 32'h0,   32'h200, 1'b0, 1'b0, 1'b1, 1'b0, 0, 1};
        vecs[8]  = '{32'h100,      1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b1, 32'h200, 1'b1, 32'h300, 32'h300, 1'b0, 1'b0, 1'b1, 1'b0, 0, 1};
        vecs[9]  = '{32'h100,      1'b0, 1'b1, 5'd0, 5'd5, 5'd5, 5'd2, 1'b1, 1'b1, 1'b1, 32'h200, 1'b0, 32'h0,   32'h104, 1'b1, 1'b1, 1'b0, 1'b1, 1, 0};
        vecs[10] = '{32'h100,      1'b0, 1'b1, 5'd0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b1, 1'b1, 32'h200, 1'b0, 32'h0,   32'h200, 1'b0, 1'b0, 1'b1, 1'b0, 0, 1};
        vecs[11] = '{32'h100,      1'b0, 1'b1, 5'd0, 5'd5, 5'd5, 5'd2, 1'b1, 1'b0, 1'b0, 32'h0,   1'b1, 32'h400, 32'h400, 1'b0, 1'b0, 1'b1, 1'b0, 0, 1};
        vecs[12] = '{32'h100,      1'b0, 1'b1, 5'd0, 5'd6, 5'd1, 5'd6, 1'b0, 1'b1, 1'b0, 32'h0,   1'b0, 32'h0,   32'h104, 1'b1, 1'b1, 1'b0, 1'b1, 1, 0};

        // Reset with a nonzero PC present
        reset = 1'b1;
        clearInputs(32'h40);
        @(negedge clk);
        #1;
        checkOutput("reset pc_next", pc_next, 32'h0);
        checkOutput("reset pc_hold", {31'd0, pc_hold}, 32'd0);
        checkOutput("reset ifid_flush", {31'd0, ifid_flush}, 32'd1);
        checkOutput("reset idex_flush", {31'd0, idex_flush}, 32'd1);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        checkCounters("post-reset");
        checkOutput("post-reset pc_next", pc_next, 32'h44);
        checkOutput("post-reset halted", {31'd0, halted}, 32'd0);

        for (int i = 0; i < NVEC; i++) begin
            @(negedge clk);
            applyStimulus(vecs[i]);
            #1;
            checkOutput($sformatf("vec%0d pc_next", i), pc_next, vecs[i].e_pc_next);
            checkOutput($sformatf("vec%0d pc_hold", i), {31'd0, pc_hold}, {31'd0, vecs[i].e_pc_hold});
            checkOutput($sformatf("vec%0d ifid_hold", i), {31'd0, ifid_hold}, {31'd0, vecs[i].e_ifid_hold});
            checkOutput($sformatf("vec%0d ifid_flush", i), {31'd0, ifid_flush}, {31'd0, vecs[i].e_ifid_flush});
            checkOutput($sformatf("vec%0d idex_flush", i), {31'd0, idex_flush}, {31'd0, vecs[i].e_idex_flush});
            @(posedge clk);
            #1;
            exp_stall += vecs[i].e_stall_inc;
            exp_flush += vecs[i].e_flush_inc;
            checkCounters($sformatf("vec%0d", i));
        end

        // Halt accepted, four drain edges, then HALTED until reset
        @(negedge clk);
        clearInputs(32'h500);
        halt = 1'b1;
        #1;
        checkOutput("halt pc_hold", {31'd0, pc_hold}, 32'd1);
        checkOutput("halt ifid_flush", {31'd0, ifid_flush}, 32'd1);
        checkOutput("halt halted", {31'd0, halted}, 32'd0);
        @(posedge clk);
        @(negedge clk);
        halt          = 1'b0;
        jump          = 1'b1;
        jump_target   = 32'h600;
        idex_mem_read = 1'b1;
        idex_rt       = 5'd4;
        ifid_rs       = 5'd4;
        for (int i = 1; i <= 4; i++) begin
            #1;
            checkOutput($sformatf("drain%0d halted", i), {31'd0, halted}, 32'd0);
            checkOutput($sformatf("drain%0d pc_hold", i), {31'd0, pc_hold}, 32'd1);
            checkOutput($sformatf("drain%0d pc_next", i), pc_next, 32'h500);
            checkOutput($sformatf("drain%0d ifid_hold", i), {31'd0, ifid_hold}, 32'd0);
            @(posedge clk);
            @(negedge clk);
        end
        for (int i = 0; i < 3; i++) begin
            #1;
            checkOutput($sformatf("halted%0d halted", i), {31'd0, halted}, 32'd1);
            checkOutput($sformatf("halted%0d pc_hold", i), {31'd0, pc_hold}, 32'd1);
            checkOutput($sformatf("halted%0d pc_next", i), pc_next, 32'h500);
            @(posedge clk);
            @(negedge clk);
        end
        checkCounters("after halt");

        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        clearInputs(32'h700);
        exp_stall = 0;
        exp_flush = 0;
        #1;
        checkCounters("reset from halted");
        checkOutput("reset from halted halted", {31'd0, halted}, 32'd0);
        checkOutput("reset from halted pc_next", pc_next, 32'h704);

        // Reset arriving at the second drain edge returns to RUN
        @(negedge clk);
        clearInputs(32'h800);
        halt = 1'b1;
        @(posedge clk);
        @(negedge clk);
        halt = 1'b0;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        #1;
        checkOutput("mid-drain reset pc_next", pc_next, 32'h0);
        checkOutput("mid-drain reset pc_hold", {31'd0, pc_hold}, 32'd0);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1;
            checkOutput($sformatf("post-drain-reset%0d halted", i), {31'd0, halted}, 32'd0);
            checkOutput($sformatf("post-drain-reset%0d pc_hold", i), {31'd0, pc_hold}, 32'd0);
            checkOutput($sformatf("post-drain-reset%0d pc_next", i), pc_next, 32'h804);
            @(posedge clk);
            @(negedge clk);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
